// File: rtl/synth_pkg.sv
// Shared definitions for the note sequencer slice.
// Contents:
//   - pattern entry layout: [11:8] note, [7:6] octave, [5:4] wave, [3:0] len
//   - FSM state encoding (IDLE, LOAD, PLAY)
//   - note decoding and effective step length helpers
package synth_pkg;

    localparam int ENTRY_W   = 12;
    localparam int NOTE_HI   = 11;
    localparam int NOTE_LO   = 8;
    localparam int OCT_HI    = 7;
    localparam int OCT_LO    = 6;
    localparam int WAVE_HI   = 5;
    localparam int WAVE_LO   = 4;
    localparam int LEN_HI    = 3;
    localparam int LEN_LO    = 0;
    localparam int NUM_NOTES = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    // Notes 1..11 select one divider tap; 0 and 12..15 are rests.
    function automatic logic [NUM_NOTES-1:0] note_to_sw(input logic [3:0] note);
        logic [NUM_NOTES-1:0] sw;
        if ((note >= 4'd1) && (note <= 4'd11)) begin
            sw = {{(NUM_NOTES-1){1'b0}}, 1'b1} << (note - 4'd1);
        end else begin
            sw = {NUM_NOTES{1'b0}};
        end
        return sw;
    endfunction

    // A zero length still plays for one tick.
    function automatic logic [3:0] eff_len(input logic [3:0] len);
        logic [3:0] l;
        if (len == 4'd0) begin
            l = 4'd1;
        end else begin
            l = len;
        end
        return l;
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control/pattern-write bus between the config logic (master) and the
// note sequencer (slave), plus the oscillator-side outputs.
//   master drives: start, stop, loop, last_step, wr_en, wr_addr, wr_data
//   slave drives : note_sw, octave, wave, gate, step_start, step_idx, busy, done
interface note_sequencer_if #(
    parameter int IW = 4
);
    import synth_pkg::*;

    logic                 start;
    logic                 stop;
    logic                 loop;
    logic [IW-1:0]        last_step;
    logic                 wr_en;
    logic [IW-1:0]        wr_addr;
    logic [ENTRY_W-1:0]   wr_data;

    logic [NUM_NOTES-1:0] note_sw;
    logic [1:0]           octave;
    logic [1:0]           wave;
    logic                 gate;
    logic                 step_start;
    logic [IW-1:0]        step_idx;
    logic                 busy;
    logic                 done;

    modport master (
        output start, stop, loop, last_step, wr_en, wr_addr, wr_data,
        input  note_sw, octave, wave, gate, step_start, step_idx, busy, done
    );

    modport slave (
        input  start, stop, loop, last_step, wr_en, wr_addr, wr_data,
        output note_sw, octave, wave, gate, step_start, step_idx, busy, done
    );

endinterface

// File: rtl/tick_gen.sv
// Tempo tick generator: counts 0..TICK_DIV-1 and pulses tick for the one
// cycle the count sits at TICK_DIV-1. clr holds the count at 0.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (no tick while asserted)
//   tick     : one-cycle pulse per TICK_DIV cycles
module tick_gen #(
    parameter int TICK_DIV = 50000,
    parameter int TW       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [TW-1:0] CNT_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] CNT_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] CNT_ONE  = {{(TW-1){1'b0}}, 1'b1};

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count and wrap detection.
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_ZERO;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer driving the oscillator datapath from a 16-entry pattern.
// Each step: one LOAD cycle (latch entry, pulse step_start), then
// max(len,1) tempo ticks of PLAY. All outputs are registered.
//   clk, rst : clock, synchronous active-high reset
//   bus      : note_sequencer_if.slave (control, pattern write, outputs)
module note_sequencer
    import synth_pkg::*;
#(
    parameter int STEPS    = 16,
    parameter int TICK_DIV = 50000,
    parameter int TW       = 16
) (
    input  logic              clk,
    input  logic              rst,
    note_sequencer_if.slave   bus
);

    localparam int            IW       = $clog2(STEPS);
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};

    logic [ENTRY_W-1:0] pat_q [STEPS];
    logic [ENTRY_W-1:0] pat_d [STEPS];

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [3:0]           ticks_q, ticks_d;
    logic                 note_on_q, note_on_d;
    logic [NUM_NOTES-1:0] note_sw_q, note_sw_d;
    logic [1:0]           octave_q, octave_d;
    logic [1:0]           wave_q, wave_d;
    logic                 gate_q, gate_d;
    logic                 step_start_q, step_start_d;
    logic [IW-1:0]        step_idx_q, step_idx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 tick_s;
    logic                 tick_clr_s;
    logic [ENTRY_W-1:0]   ent_s;
    logic [NUM_NOTES-1:0] ent_sw_s;

    // The divider only runs in PLAY, so every step starts from a zero count.
    assign tick_clr_s = (state_q != PLAY);

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .TW       (TW)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr_s),
        .tick (tick_s)
    );

    // Entry read uses the registered pattern, so a same-cycle write is not seen.
    assign ent_s    = pat_q[idx_q];
    assign ent_sw_s = note_to_sw(ent_s[NOTE_HI:NOTE_LO]);

    // Pattern write port.
    always_comb begin
        for (int i = 0; i < STEPS; i++) begin
            pat_d[i] = pat_q[i];
        end
        if (bus.wr_en) begin
            pat_d[bus.wr_addr] = bus.wr_data;
        end else begin
            pat_d[bus.wr_addr] = pat_q[bus.wr_addr];
        end
    end

    // Pattern storage, cleared to rests on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                pat_q[i] <= {ENTRY_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < STEPS; i++) begin
                pat_q[i] <= pat_d[i];
            end
        end
    end

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ticks_d      = ticks_q;
        note_on_d    = note_on_q;
        note_sw_d    = note_sw_q;
        octave_d     = octave_q;
        wave_d       = wave_q;
        gate_d       = gate_q;
        step_idx_d   = step_idx_q;
        step_start_d = 1'b0;
        done_d       = 1'b0;

        if (bus.stop) begin
            state_d = IDLE;
            gate_d  = 1'b0;
        end else if (bus.start) begin
            state_d = LOAD;
            idx_d   = IDX_ZERO;
            gate_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    gate_d = 1'b0;
                end
                LOAD: begin
                    note_sw_d    = ent_sw_s;
                    note_on_d    = |ent_sw_s;
                    octave_d     = ent_s[OCT_HI:OCT_LO];
                    wave_d       = ent_s[WAVE_HI:WAVE_LO];
                    step_idx_d   = idx_q;
                    ticks_d      = eff_len(ent_s[LEN_HI:LEN_LO]);
                    step_start_d = 1'b1;
                    gate_d       = |ent_sw_s;
                    state_d      = PLAY;
                end
                PLAY: begin
                    if (tick_s) begin
                        if (ticks_q == 4'd1) begin
                            gate_d = 1'b0;
                            if (idx_q != bus.last_step) begin
                                idx_d   = idx_q + IDX_ONE;
                                state_d = LOAD;
                            end else if (bus.loop) begin
                                idx_d   = IDX_ZERO;
                                state_d = LOAD;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            ticks_d = ticks_q - 4'd1;
                            // Entering the final tick of a multi-tick step opens the articulation gap.
                            gate_d  = note_on_q & (ticks_q != 4'd2);
                        end
                    end else begin
                        gate_d = gate_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    gate_d  = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= IDX_ZERO;
            ticks_q      <= 4'd0;
            note_on_q    <= 1'b0;
            note_sw_q    <= {NUM_NOTES{1'b0}};
            octave_q     <= 2'd0;
            wave_q       <= 2'd0;
            gate_q       <= 1'b0;
            step_start_q <= 1'b0;
            step_idx_q   <= IDX_ZERO;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ticks_q      <= ticks_d;
            note_on_q    <= note_on_d;
            note_sw_q    <= note_sw_d;
            octave_q     <= octave_d;
            wave_q       <= wave_d;
            gate_q       <= gate_d;
            step_start_q <= step_start_d;
            step_idx_q   <= step_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.note_sw    = note_sw_q;
    assign bus.octave     = octave_q;
    assign bus.wave       = wave_q;
    assign bus.gate       = gate_q;
    assign bus.step_start = step_start_q;
    assign bus.step_idx   = step_idx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Step sequencer that drives the oscillator datapath: note switch vector, octave, waveform select, gate (oscillator enable) and a phase-restart pulse at each step.
- Holds a 16-entry programmable pattern and plays it at a tempo derived from clk.
- Sits between the user/config logic and the frequency-divider, table-counter and waveform-select blocks.
- Replaces direct switch/button control of the oscillator when running.

Parameters:
- STEPS, 16, pattern depth; power of two; index width = log2(STEPS).
- TICK_DIV, 50000, clk cycles per tempo tick; minimum 2.
- TW, 16, tick divider counter width; must satisfy 2^TW > TICK_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse; begin playback at step 0
- stop  in  1  single-cycle pulse; abort playback
- loop  in  1  1 = wrap after last_step, 0 = stop after last_step
- last_step  in  4  index of final step played
- wr_en  in  1  pattern write strobe
- wr_addr  in  4  pattern write address
- wr_data  in  12  entry: [11:8] note, [7:6] octave, [5:4] wave, [3:0] len
- note_sw  out  11  one-hot frequency select to divider (bit n-1 = note n)
- octave  out  2  octave select
- wave  out  2  waveform select
- gate  out  1  oscillator enable
- step_start  out  1  one-cycle pulse at each step load; drives table-counter restart
- step_idx  out  4  current step index
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse when a non-looping pattern ends

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM enters IDLE.
  - All pattern entries are cleared to 0 (rest, len 0).
- Pattern RAM: 16x12 registers. A write takes effect on the next clk edge. A LOAD in the same cycle as a write to the same address reads the old data.
- States:
  - IDLE: outputs hold their last values except gate=0 and busy=0.
    - start -> LOAD, with idx=0.
  - LOAD: one cycle.
    - Latch entry[idx] into the output registers.
    - step_start=1.
    - ticks_left = (len==0 ? 1 : len).
    - Clear the tick divider.
    - Next state -> PLAY.
  - PLAY: the tick divider counts 0..TICK_DIV-1 and emits a tick on wrap. Each tick decrements ticks_left.
    - On the tick where ticks_left==1:
      - If idx != last_step: idx+1 -> LOAD.
      - Else, if loop: idx=0 -> LOAD.
      - Else: -> IDLE, done=1 for one cycle, gate=0.
- Step duration is exactly 1 + max(len,1)*TICK_DIV clk cycles.
- Gate and note mapping:
  - note 1..11: note_sw = one-hot bit (note-1), gate=1 in PLAY.
  - note 0 or 12..15: rest. note_sw=0, gate=0.
  - Articulation gap: when effective len>=2, gate drops to 0 during the final tick of the step. When len<=1, gate stays high for the whole PLAY.
  - Gate is 0 during LOAD cycles.
- octave and wave update only in LOAD.
- step_idx equals idx and updates in LOAD.
- stop: from any state -> IDLE on the next edge. gate=0, no done pulse.
- start while busy: restarts at step 0 (-> LOAD, idx=0).
- start and stop in the same cycle: stop wins.
- last_step beyond the written entries: plays the cleared or stale entries; no special case.
- last_step changed mid-play: compared live at each step end.
- wr_en during playback: allowed. The new data is used the next time that index is loaded.
- rst mid-operation: immediate return to the reset state; pattern is cleared.

Decomposition:
- Package synth_pkg:
  - Entry field offsets (NOTE_HI/LO, OCT_HI/LO, WAVE_HI/LO, LEN_HI/LO).
  - FSM state encoding: IDLE, LOAD, PLAY.
  - Constant NUM_NOTES=11.
- Sub-module tick_gen: TICK_DIV counter with synchronous clear, outputs a one-cycle tick pulse.
- Pattern RAM and FSM stay in note_sequencer.

Test Plan:
- Reset: assert rst 3 cycles -> all outputs 0, busy=0. A read-back play of step 0 gives gate=0 (rest).
- Single note, TICK_DIV=4: write addr0 = note 3, oct 1, wave 2, len 3; last_step=0; loop=0; pulse start. Required response:
  - step_start after 1 cycle; note_sw=11'b100, octave=1, wave=2.
  - gate high 8 cycles then low 4; done pulse at cycle 13; busy low after.
- Loop and rest: steps 0..2 = note 1 len 1, rest len 2, note 11 len 1; last_step=2; loop=1. Required response:
  - step_idx sequence 0,1,2,0,…
  - step_start spacing 5, 9, 5 cycles.
  - gate=0 throughout step 1; note_sw=11'h400 on step 2.
- Stop mid-step, and start+stop same cycle: pulse stop during PLAY -> IDLE next cycle, gate=0, no done. A simultaneous start+stop leaves busy=0.
- Write during play: while step 1 plays with loop=1, rewrite addr1 to note 5 -> the current step is unchanged. The next pass shows note_sw=11'h010 at step 1.
- len=0 edge: entry with len 0 -> step lasts 1+TICK_DIV cycles. Gate stays high the whole PLAY, with no articulation gap.
